// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq: sequential radix-2 Booth multiplier for signed or
// unsigned operands. One Booth step retires per clock; the product is valid
// WIDTH+1 clocks after start is accepted and is held until the next result.
module booth_multiplier_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Operands carry one extra bit so unsigned values stay positive under Booth
    localparam int unsigned E  = WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [E:0]           acc_q, acc_d;
    logic [E-1:0]         q_q, q_d;
    logic [E-1:0]         m_q, m_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic                 load;
    logic [E-1:0]         a_ext, b_ext;
    logic [E:0]           m_ext, sum;
    logic [2*E+1:0]       full, shifted;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Booth step, next-state logic and operand capture
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        a_ext = {signed_mode & a[WIDTH-1], a};
        b_ext = {signed_mode & b[WIDTH-1], b};
        m_ext = {m_q[E-1], m_q};

        sum = acc_q;
        case ({q_q[0], qm1_q})
            2'b10:   sum = acc_q - m_ext;
            2'b01:   sum = acc_q + m_ext;
            default: sum = acc_q;
        endcase

        // Arithmetic shift of {ACC, Q, q_m1}, replicating the guard bit
        full    = {sum, q_q, qm1_q};
        shifted = {sum[E], full[2*E+1:1]};

        load = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = shifted[2*E+1:E+1];
                q_d   = shifted[E:1];
                qm1_d = shifted[0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    product_d = shifted[2*WIDTH:1];
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            m_d   = b_ext;
            q_d   = a_ext;
            qm1_d = 1'b0;
            acc_d = '0;
            cnt_d = CW'(E);
        end
    end

    // Outputs decode directly from registered state
    always_comb begin
        busy    = (state_q == StRun);
        done    = (state_q == StDone);
        product = product_q;
    end

endmodule
